// File: rtl/tetris_field_render.sv
// Tetris playfield pixel source: a 10x20 cell colour map rendered into a raster-ordered
// 24-bit RGB stream with a valid/ready handshake and credit-limited output buffering.
module tetris_field_render #(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720,
  parameter int FIELD_X   = 480,
  parameter int FIELD_Y   = 40,
  parameter int CELL_LOG2 = 5
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        i_cell_wen,
  input  logic [4:0]  i_cell_row,
  input  logic [3:0]  i_cell_col,
  input  logic [2:0]  i_cell_color,
  input  logic        i_clear,
  output logic [23:0] Video,
  output logic        VideoValid,
  input  logic        VideoReady,
  output logic        o_sof,
  output logic        o_busy
);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int FIELD_W = 10 << CELL_LOG2;
  localparam int FIELD_H = 20 << CELL_LOG2;
  localparam int NCELLS  = 200;

  // Clear sweep and RAM write port
  logic       busy_q, busy_d;
  logic [7:0] clr_addr_q, clr_addr_d;
  logic       game_wr, ram_we;
  logic [7:0] game_addr, ram_waddr;
  logic [2:0] ram_wdata;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
    busy_d     = busy_q;
    clr_addr_d = clr_addr_q;
    if (i_clear) begin
      busy_d     = 1'b1;
      clr_addr_d = 8'd0;
    end else if (busy_q) begin
      if (clr_addr_q == 8'(NCELLS - 1)) busy_d = 1'b0;
      clr_addr_d = clr_addr_q + 8'd1;
    end
  end

  assign game_addr = {3'b000, i_cell_row} * 8'd10 + {4'b0000, i_cell_col};
  assign game_wr   = i_cell_wen && !i_clear && !busy_q &&
                     (i_cell_row < 5'd20) && (i_cell_col < 4'd10);
  assign ram_we    = busy_q || game_wr;
  assign ram_waddr = busy_q ? clr_addr_q : game_addr;
  assign ram_wdata = busy_q ? 3'd0 : i_cell_color;

  // Raster counters, credit check and S0 decode
  logic          start_q;
  logic [XW-1:0] x_q, x_d, lx;
  logic [YW-1:0] y_q, y_d, ly;
  logic [1:0]    count_q;
  logic          s1_valid_q, pop, issue;
  logic [2:0]    credit_used;
  logic          s0_inside, s0_edge, s0_sof;
  logic [3:0]    s0_col;
  logic [4:0]    s0_row;
  logic [7:0]    rd_addr;

  assign pop         = VideoValid && VideoReady;
  // The slot freed by this cycle's pop is reusable now, which sustains 1 px/clk.
  assign credit_used = {1'b0, count_q} + {2'b00, s1_valid_q} - {2'b00, pop};
  assign issue       = start_q && (credit_used < 3'd2);

  assign lx        = x_q - XW'(FIELD_X);
  assign ly        = y_q - YW'(FIELD_Y);
  assign s0_inside = (int'(x_q) >= FIELD_X) && (int'(x_q) < FIELD_X + FIELD_W) &&
                     (int'(y_q) >= FIELD_Y) && (int'(y_q) < FIELD_Y + FIELD_H);
  assign s0_edge   = (lx[CELL_LOG2-1:0] == '0) || (ly[CELL_LOG2-1:0] == '0);
  assign s0_col    = 4'(lx >> CELL_LOG2);
  assign s0_row    = 5'(ly >> CELL_LOG2);
  assign s0_sof    = (x_q == '0) && (y_q == '0);
  assign rd_addr   = s0_inside ? ({3'b000, s0_row} * 8'd10 + {4'b0000, s0_col}) : 8'd0;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (issue) begin
      if (x_q == XW'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Cell RAM: read-first, synchronous read forms the S1 data register
  logic [2:0] cell_mem [NCELLS];
  logic [2:0] rd_q;

  // NOTE: the cell array is deliberately not reset so it maps onto a RAM; i_clear initialises it.
  always_ff @(posedge Clock) begin
    if (ram_we) cell_mem[ram_waddr] <= ram_wdata;
    if (issue)  rd_q <= cell_mem[rd_addr];
  end

  // S1 flags, S2 palette, 2-entry output FIFO
  logic        s1_inside_q, s1_edge_q, s1_sof_q;
  logic [23:0] pix_rgb;
  logic [24:0] fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;

  always_comb begin
    pix_rgb = 24'h202020;
    if (s1_inside_q) begin
      if (s1_edge_q) begin
        pix_rgb = 24'h404040;
      end else begin
        case (rd_q)
          3'd1:    pix_rgb = 24'h00FFFF;
          3'd2:    pix_rgb = 24'hFFFF00;
          3'd3:    pix_rgb = 24'h800080;
          3'd4:    pix_rgb = 24'h00FF00;
          3'd5:    pix_rgb = 24'hFF0000;
          3'd6:    pix_rgb = 24'h0000FF;
          3'd7:    pix_rgb = 24'hFFA500;
          default: pix_rgb = 24'h000000;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_q      <= 1'b0;
      clr_addr_q  <= 8'd0;
      start_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_inside_q <= 1'b0;
      s1_edge_q   <= 1'b0;
      s1_sof_q    <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      busy_q     <= busy_d;
      clr_addr_q <= clr_addr_d;
      start_q    <= 1'b1;
      x_q        <= x_d;
      y_q        <= y_d;
      s1_valid_q <= issue;
      if (issue) begin
        s1_inside_q <= s0_inside;
        s1_edge_q   <= s0_edge;
        s1_sof_q    <= s0_sof;
      end
      if (s1_valid_q) fifo_q[wr_ptr_q] <= {s1_sof_q, pix_rgb};
      wr_ptr_q <= wr_ptr_q ^ s1_valid_q;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_q + {1'b0, s1_valid_q} - {1'b0, pop};
    end
  end

  assign VideoValid = (count_q != 2'd0);
  assign Video      = fifo_q[rd_ptr_q][23:0];
  assign o_sof      = VideoValid && fifo_q[rd_ptr_q][24];
  assign o_busy     = busy_q;
endmodule

// File: tb/tb_tetris_field_render.sv
// Directed bench for tetris_field_render on a scaled-down raster (48x88, 4 px cells)
// with a bench-side raster/palette model of the expected frame.
module tb_tetris_field_render;
  localparam int H     = 48;
  localparam int V     = 88;
  localparam int FX    = 4;
  localparam int FY    = 4;
  localparam int CL    = 2;
  localparam int CS    = 1 << CL;
  localparam int FRAME = H * V;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cell_wen = 1'b0;
  logic [4:0]  i_cell_row = '0;
  logic [3:0]  i_cell_col = '0;
  logic [2:0]  i_cell_color = '0;
  logic        i_clear = 1'b0;
  logic [23:0] Video;
  logic        VideoValid;
  logic        VideoReady = 1'b1;
  logic        o_sof;
  logic        o_busy;

  always #5 clk = ~clk;

  tetris_field_render #(
    .H_ACTIVE(H), .V_ACTIVE(V), .FIELD_X(FX), .FIELD_Y(FY), .CELL_LOG2(CL)
  ) dut (
    .Clock(clk), .Reset(rst),
    .i_cell_wen(i_cell_wen), .i_cell_row(i_cell_row), .i_cell_col(i_cell_col),
    .i_cell_color(i_cell_color), .i_clear(i_clear),
    .Video(Video), .VideoValid(VideoValid), .VideoReady(VideoReady),
    .o_sof(o_sof), .o_busy(o_busy)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int          cells [200];
  int          mx = 0;
  int          my = 0;
  logic [23:0] frame_buf [FRAME];
  logic [23:0] prev_buf [FRAME];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] exp_rgb(input int x, input int y);
    int lx, ly;
    if (x < FX || x >= FX + 10 * CS || y < FY || y >= FY + 20 * CS) return 24'h202020;
    lx = x - FX;
    ly = y - FY;
    if (lx % CS == 0 || ly % CS == 0) return 24'h404040;
    case (cells[(ly / CS) * 10 + lx / CS])
      1:       return 24'h00FFFF;
      2:       return 24'hFFFF00;
      3:       return 24'h800080;
      4:       return 24'h00FF00;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      7:       return 24'hFFA500;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic write_cell(input int row, input int col, input int color);
    i_cell_wen   = 1'b1;
    i_cell_row   = 5'(row);
    i_cell_col   = 4'(col);
    i_cell_color = 3'(color);
    @(negedge clk);
    i_cell_wen = 1'b0;
    if (row < 20 && col < 10) cells[row * 10 + col] = color;
  endtask

  // Accepts npx pixels with VideoReady at duty% and compares them with the model raster.
  task automatic stream(input string tag, input int npx, input int duty, input bit check_rgb);
    int   got = 0, cyc = 0, bad_rgb = 0, bad_sof = 0, bad_stall = 0;
    int   budget = npx * 20 + 200;
    bit   stalled = 1'b0;
    logic [24:0] held = '0;
    while (got < npx && cyc < budget) begin
      if (stalled && !(VideoValid === 1'b1 && {o_sof, Video} === held)) bad_stall++;
      VideoReady = ($urandom_range(99) < duty);
      if (VideoValid && VideoReady) begin
        frame_buf[my * H + mx] = Video;
        if (check_rgb && Video !== exp_rgb(mx, my)) bad_rgb++;
        if (o_sof !== 1'(mx == 0 && my == 0)) bad_sof++;
        if (mx == H - 1) begin
          mx = 0;
          my = (my == V - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
        got++;
      end
      stalled = VideoValid && !VideoReady;
      held    = {o_sof, Video};
      @(negedge clk);
      cyc++;
    end
    VideoReady = 1'b0;
    check({tag, "_accepted"}, got, npx);
    if (check_rgb) check({tag, "_rgb_errs"}, bad_rgb, 0);
    check({tag, "_sof_errs"}, bad_sof, 0);
    check({tag, "_stall_errs"}, bad_stall, 0);
  endtask

  task automatic measure_busy(input int wr_at, input int clr_at, output int n);
    n = 0;
    while (o_busy && n < 1000) begin
      i_cell_wen = (n == wr_at);
      i_clear    = (n == clr_at);
      n++;
      @(negedge clk);
    end
    i_cell_wen = 1'b0;
    i_clear    = 1'b0;
  endtask

  initial begin
    int busy_cyc, diffs, orange;

    repeat (3) @(negedge clk);
    check("rst_valid", VideoValid, 0);
    check("rst_video", Video, 0);
    check("rst_sof", o_sof, 0);
    check("rst_busy", o_busy, 0);

    // Release reset with a clear pulse; first pixel must be visible after the 3rd edge.
    rst = 1'b0;
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    check("edge1_valid", VideoValid, 0);
    check("clear_busy", o_busy, 1);
    @(negedge clk);
    check("edge2_valid", VideoValid, 0);
    @(negedge clk);
    check("edge3_valid", VideoValid, 1);
    check("first_rgb", Video, 24'h202020);
    check("first_sof", o_sof, 1);
    stream("frame1", FRAME, 100, 1'b0);
    check("frame1_next_sof", {VideoValid, o_sof}, 2'b11);

    // Directed cell writes while the stream is stalled at the frame start.
    write_cell(0, 0, 5);
    write_cell(19, 9, 1);
    write_cell(10, 4, 7);
    write_cell(5, 2, 3);
    write_cell(7, 8, 2);
    write_cell(12, 1, 4);
    write_cell(3, 6, 6);
    stream("frame2", FRAME, 100, 1'b1);
    check("px_in_cell", frame_buf[(FY + 1) * H + FX + 1], 24'hFF0000);
    check("px_corner", frame_buf[FY * H + FX], 24'h404040);
    check("px_next_cell", frame_buf[(FY + 1) * H + FX + CS + 1], 24'h000000);

    stream("rand30", 2 * FRAME, 30, 1'b1);
    check("rand30_next_sof", {VideoValid, o_sof}, 2'b11);
    prev_buf = frame_buf;

    // Out-of-range writes must leave the frame untouched.
    write_cell(20, 0, 3);
    write_cell(0, 10, 3);
    write_cell(31, 15, 3);
    stream("bad_addr", FRAME, 100, 1'b1);
    diffs = 0;
    for (int i = 0; i < FRAME; i++) if (frame_buf[i] !== prev_buf[i]) diffs++;
    check("bad_addr_vs_prev", diffs, 0);
    check("bad_addr_row1_col0", frame_buf[(FY + CS + 1) * H + FX + 1], 24'h000000);

    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) write_cell(r, c, 7);
    stream("fill7", FRAME, 100, 1'b1);
    check("fill7_px", frame_buf[(FY + 1) * H + FX + 1], 24'hFFA500);

    // Clear sweep: exactly 200 busy cycles; a write during the sweep is dropped.
    i_clear = 1'b1;
    @(negedge clk);
    i_clear      = 1'b0;
    i_cell_row   = 5'd3;
    i_cell_col   = 4'd3;
    i_cell_color = 3'd2;
    measure_busy(50, -1, busy_cyc);
    check("busy_cycles", busy_cyc, 200);
    for (int i = 0; i < 200; i++) cells[i] = 0;
    stream("cleared", FRAME, 100, 1'b1);
    orange = 0;
    for (int i = 0; i < FRAME; i++) if (frame_buf[i] === 24'hFFA500) orange++;
    check("cleared_orange", orange, 0);

    // A clear pulse mid-sweep restarts it at address 0.
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    measure_busy(-1, 100, busy_cyc);
    check("restart_busy_cycles", busy_cyc, 301);

    // Reset in mid-frame: outputs clear at once, stream restarts, cells survive.
    write_cell(2, 3, 4);
    write_cell(15, 7, 5);
    stream("pre_reset", 50 * H + 30, 100, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", VideoValid, 0);
    check("mid_rst_video", Video, 0);
    @(negedge clk);
    check("mid_rst_valid_hold", VideoValid, 0);
    @(negedge clk);
    rst = 1'b0;
    mx = 0;
    my = 0;
    stream("post_reset", FRAME, 100, 1'b1);
    check("post_reset_cell", frame_buf[(FY + 2 * CS + 1) * H + FX + 3 * CS + 1], 24'h00FF00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
